// File: rtl/stack_if.sv
// Push/pop request and status bundle for the LIFO stack.
// The master drives requests and data; the slave (the stack) returns data and status.
interface stack_if #(
  parameter int WIDTH_DATA = 32,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  push;
  logic                  pop;
  logic [WIDTH_DATA-1:0] data_in;
  logic [WIDTH_DATA-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, data_in,
    input  data_out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/stack.sv
// Synchronous LIFO stack with a registered read port, occupancy count and
// single-cycle overflow/underflow pulses.
module stack #(
  parameter int WIDTH_DATA = 32,
  parameter int DEPTH      = 16
) (
  input  logic    clk,
  input  logic    reset,
  stack_if.slave  s
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH_DATA-1:0] mem [DEPTH];

  logic [CNT_W-1:0]      count_p1;
  logic [WIDTH_DATA-1:0] dout_p1;
  logic                  ovf_p1;
  logic                  udf_p1;

  logic          is_full;
  logic          is_empty;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic          rd_en;
  logic          inc;
  logic          dec;

  assign is_full  = (count_p1 == DEPTH_C);
  assign is_empty = (count_p1 == '0);

  // Index truncation is safe: top_idx is only used when not empty and
  // nxt_idx only when not full, so both stay below DEPTH.
  assign top_idx = AW'(count_p1 - CNT_W'(1));
  assign nxt_idx = AW'(count_p1);

  // A simultaneous push/pop on a non-empty stack replaces the top word in place;
  // on an empty stack the pop is dropped and the push lands at the bottom.
  assign rd_en  = s.pop && !is_empty;
  assign wr_en  = s.push && (s.pop || !is_full);
  assign wr_idx = rd_en ? top_idx : nxt_idx;
  assign inc    = s.push && !is_full && (!s.pop || is_empty);
  assign dec    = s.pop && !s.push && !is_empty;

  // Storage is never cleared; only the count defines which entries are live.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_idx] <= s.data_in;
    end
  end

  // Edge p0 -> p1: count, read data and error pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_p1 <= '0;
      dout_p1  <= '0;
      ovf_p1   <= 1'b0;
      udf_p1   <= 1'b0;
    end else begin
      ovf_p1 <= s.push && !s.pop && is_full;
      udf_p1 <= s.pop && is_empty;
      if (rd_en) begin
        dout_p1 <= mem[top_idx];
      end
      if (inc) begin
        count_p1 <= count_p1 + CNT_W'(1);
      end else if (dec) begin
        count_p1 <= count_p1 - CNT_W'(1);
      end
    end
  end

  assign s.data_out  = dout_p1;
  assign s.count     = count_p1;
  assign s.full      = is_full;
  assign s.empty     = is_empty;
  assign s.overflow  = ovf_p1;
  assign s.underflow = udf_p1;
endmodule

// File: tb/tb_stack.sv
// Scoreboard bench for the stack: a queue-based reference model predicts every
// post-edge state; a monitor on the falling edge compares it against the DUT.
module tb_stack;
  localparam int WD    = 32;
  localparam int DEPTH = 10;

  typedef struct {
    logic [WD-1:0] dout;
    int            cnt;
    bit            full;
    bit            empty;
    bit            ovf;
    bit            udf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  stack_if #(.WIDTH_DATA(WD), .DEPTH(DEPTH)) bus ();

  stack #(.WIDTH_DATA(WD), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model: the stack is a plain queue, top at the back.
  logic [WD-1:0] mstk[$];
  logic [WD-1:0] mdout = '0;
  bit            movf  = 1'b0;
  bit            mudf  = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    if (!reset) begin
      mstk.delete();
      mdout = '0;
      movf  = 1'b0;
      mudf  = 1'b0;
    end else begin
      movf = 1'b0;
      mudf = 1'b0;
      if (bus.push && bus.pop) begin
        if (mstk.size() == 0) begin
          mstk.push_back(bus.data_in);
          mudf = 1'b1;
        end else begin
          mdout = mstk.pop_back();
          mstk.push_back(bus.data_in);
        end
      end else if (bus.push) begin
        if (mstk.size() == DEPTH) movf = 1'b1;
        else mstk.push_back(bus.data_in);
      end else if (bus.pop) begin
        if (mstk.size() == 0) mudf = 1'b1;
        else mdout = mstk.pop_back();
      end
    end
    e.dout  = mdout;
    e.cnt   = mstk.size();
    e.full  = (mstk.size() == DEPTH);
    e.empty = (mstk.size() == 0);
    e.ovf   = movf;
    e.udf   = mudf;
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data_out",  longint'(bus.data_out), longint'(e.dout));
      chk("count",     longint'(bus.count),    longint'(e.cnt));
      chk("full",      longint'(bus.full),     longint'(e.full));
      chk("empty",     longint'(bus.empty),    longint'(e.empty));
      chk("overflow",  longint'(bus.overflow), longint'(e.ovf));
      chk("underflow", longint'(bus.underflow),longint'(e.udf));
    end
  end

  task automatic step(input bit rst_n, input bit p, input bit q, input logic [WD-1:0] d);
    @(negedge clk);
    reset        = rst_n;
    bus.push     = p;
    bus.pop      = q;
    bus.data_in  = d;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    reset       = 1'b0;
    @(posedge clk);
    step(1'b0, 1'b0, 1'b0, '0);

    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 1'b0, WD'(i));
    for (int i = 0; i < 6; i++)  step(1'b1, 1'b0, 1'b1, '0);

    for (int i = 1; i <= 11; i++) step(1'b1, 1'b1, 1'b0, WD'(i));
    step(1'b1, 1'b0, 1'b1, '0);

    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 32'd7);
    step(1'b1, 1'b1, 1'b0, 32'd8);
    step(1'b1, 1'b1, 1'b1, 32'd99);
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, '0);

    step(1'b1, 1'b1, 1'b1, 32'd42);
    step(1'b1, 1'b0, 1'b1, '0);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, WD'(100 + i));
    step(1'b1, 1'b1, 1'b1, 32'd555);
    step(1'b1, 1'b0, 1'b1, '0);

    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 1'b0, WD'(200 + i));
    step(1'b0, 1'b1, 1'b0, 32'd77);
    step(1'b1, 1'b0, 1'b1, '0);

    // Glitch reset low between edges; it must be ignored.
    step(1'b1, 1'b1, 1'b0, 32'd300);
    @(negedge clk);
    bus.push = 1'b0;
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    step(1'b1, 1'b0, 1'b1, '0);

    for (int i = 0; i < 600; i++) begin
      bit      pbias;
      int unsigned r;
      pbias = ((i / 60) % 2) == 0;
      r = $urandom_range(0, 99);
      step(($urandom_range(0, 99) != 0),
           pbias ? (r < 70) : (r < 30),
           ($urandom_range(0, 99) < (pbias ? 30 : 70)),
           WD'($urandom));
    end

    step(1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
